// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and parameter-range checks
// for the radix-2 FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fft_state_e;

  localparam int LOG2N_MIN  = 2;
  localparam int LOG2N_MAX  = 10;
  localparam int BF_LAT_MAX = 7;

  function automatic bit fft_params_ok(
    input int log2n,
    input int bf_lat
  );
    return log2n >= LOG2N_MIN
        && log2n <= LOG2N_MAX
        && bf_lat >= 0
        && bf_lat <= BF_LAT_MAX;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Controller <-> sequencer bundle: start/stall
// in, issue and write-back addressing out.
interface fft_stage_sequencer_if #(
  parameter int LOG2N = 4
);
  localparam int SW = $clog2(LOG2N);

  logic             i_start;
  logic             i_stall;
  logic             o_busy;
  logic             o_done;
  logic [SW-1:0]    o_stage;
  logic [1:0]       o_mux_sel;
  logic             o_bf_valid;
  logic [LOG2N-1:0] o_rd_addr_a;
  logic [LOG2N-1:0] o_rd_addr_b;
  logic [LOG2N-2:0] o_tw_addr;
  logic             o_wr_en;
  logic [LOG2N-1:0] o_wr_addr_a;
  logic [LOG2N-1:0] o_wr_addr_b;

  modport master (
    output i_start, i_stall,
    input  o_busy, o_done, o_stage,
    input  o_mux_sel, o_bf_valid,
    input  o_rd_addr_a, o_rd_addr_b,
    input  o_tw_addr, o_wr_en,
    input  o_wr_addr_a, o_wr_addr_b
  );

  modport slave (
    input  i_start, i_stall,
    output o_busy, o_done, o_stage,
    output o_mux_sel, o_bf_valid,
    output o_rd_addr_a, o_rd_addr_b,
    output o_tw_addr, o_wr_en,
    output o_wr_addr_a, o_wr_addr_b
  );

endinterface

// File: rtl/fft_stage_sequencer_delay_line.sv
// Async-reset shift register; DEPTH=0 is a
// plain wire so a zero-latency datapath works.
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign o_q = i_d;
  end else begin : g_sr
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < DEPTH; i++)
          r_sr[i] <= '0;
      end else begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++)
          r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_q = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT sequencer: walks LOG2N stages of
// N/2 butterflies, drains BF_LAT cycles per stage.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  fft_stage_sequencer_if.slave bus
);

  localparam int SW   = $clog2(LOG2N);
  localparam int HALF = 1 << (LOG2N - 1);
  localparam int DW   = 1 + 2 * LOG2N;

  if (!fft_params_ok(LOG2N, BF_LAT)) begin : g_bad
    $error("fft_stage_sequencer: illegal LOG2N/BF_LAT");
  end

  fft_state_e       r_state;
  logic [SW-1:0]    r_stage;
  logic [LOG2N-1:0] r_nidx;
  logic [2:0]       r_drain;
  logic             r_busy;
  logic             r_done;
  logic             r_bf_valid;
  logic [LOG2N-1:0] r_rd_a;
  logic [LOG2N-1:0] r_rd_b;
  logic [LOG2N-2:0] r_tw;

  logic             w_all;
  logic             w_last;
  logic             w_adv;
  logic             w_enter;
  logic             w_issue;
  logic [SW-1:0]    w_s;
  logic [LOG2N-2:0] w_b;
  logic [LOG2N-1:0] w_bx;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_bb;
  logic [LOG2N-2:0] w_tw;
  logic [DW-1:0]    w_wb;

  // r_nidx counts butterflies already issued in
  // this stage; outputs are prepared one edge early.
  always_comb begin
    w_all   = r_nidx == LOG2N'(HALF);
    w_last  = r_stage == SW'(LOG2N - 1);
    w_adv   = !w_last &&
              ((r_state == ST_RUN && w_all &&
                BF_LAT == 0) ||
               (r_state == ST_DRAIN &&
                r_drain == 3'd0));
    w_enter = (r_state == ST_IDLE && bus.i_start)
              || w_adv;
    w_issue = !bus.i_stall &&
              (w_enter ||
               (r_state == ST_RUN && !w_all));
  end

  always_comb begin
    w_s    = (r_state == ST_IDLE) ? '0 :
             (w_adv ? r_stage + SW'(1) : r_stage);
    w_b    = w_enter ? '0 : r_nidx[LOG2N-2:0];
    w_bx   = {1'b0, w_b};
    w_span = LOG2N'(1) << w_s;
    w_pos  = w_bx & (w_span - LOG2N'(1));
    w_grp  = w_bx >> w_s;
    w_a    = (w_grp << (int'(w_s) + 1)) | w_pos;
    w_bb   = w_a + w_span;
    w_tw   = (LOG2N-1)'(w_pos <<
             (LOG2N - 1 - int'(w_s)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_stage    <= '0;
      r_nidx     <= '0;
      r_drain    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bf_valid <= 1'b0;
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_tw       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_bf_valid <= w_issue;
      if (w_issue) begin
        r_rd_a <= w_a;
        r_rd_b <= w_bb;
        r_tw   <= w_tw;
        r_nidx <= w_enter ? LOG2N'(1) :
                  r_nidx + LOG2N'(1);
      end else if (w_enter) begin
        r_nidx <= '0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_stage <= '0;
          end
        end
        ST_RUN: begin
          if (w_all) begin
            if (BF_LAT > 0) begin
              r_state <= ST_DRAIN;
              r_drain <= 3'(BF_LAT - 1);
            end else if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stage <= r_stage + SW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain != 3'd0) begin
            r_drain <= r_drain - 3'd1;
          end else if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_stage <= r_stage + SW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fft_delay_line #(
    .WIDTH (DW),
    .DEPTH (BF_LAT)
  ) u_wb_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({r_bf_valid, r_rd_a, r_rd_b}),
    .o_q   (w_wb)
  );

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_stage     = r_stage;
  assign bus.o_mux_sel   = 2'(r_stage);
  assign bus.o_bf_valid  = r_bf_valid;
  assign bus.o_rd_addr_a = r_rd_a;
  assign bus.o_rd_addr_b = r_rd_b;
  assign bus.o_tw_addr   = r_tw;
  assign {bus.o_wr_en,
          bus.o_wr_addr_a,
          bus.o_wr_addr_b} = w_wb;

endmodule
